ac_sweep_sequencer: RTL

AC_SWEEP_SEQUENCER -- requirements
Module: ac_sweep_sequencer

---
 rtl/ac_sweep_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ac_sweep_sequencer.sv
// AC frequency-sweep sequencer: steps a stimulus frequency, waits for settling, averages ADC magnitudes, emits one result per point.
// Optional PEAK_TRACK_EN macro adds peak_freq/peak_mag tracking of the largest result in the sweep.
module ac_sweep_sequencer #(
  parameter int FW = 24,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [9:0]    n_points,
  input  logic [15:0]   settle_cycles,
  input  logic [2:0]    avg_log2,
  output logic [FW-1:0] freq_word,
  output logic          freq_load,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [DW-1:0] adc_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [FW-1:0] res_freq,
  output logic [DW-1:0] res_mag,
  output logic          busy,
`ifdef PEAK_TRACK_EN
  output logic [FW-1:0] peak_freq,
  output logic [DW-1:0] peak_mag,
`endif
  output logic          done
);

  localparam int AW = DW + 7;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EMIT, DONE} state_t;

  state_t        state, state_d;
  logic [FW-1:0] step_q, step_d;
  logic [9:0]    npts_q, npts_d;
  logic [15:0]   settle_q, settle_d;
  logic [2:0]    avg_q, avg_d;
  logic [9:0]    idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [7:0]    scnt_q, scnt_d, avg_n;
  logic [FW-1:0] freq_word_d, res_freq_d;
  logic [DW-1:0] res_mag_d;
  logic          freq_load_d, adc_req_d, res_valid_d, done_d;
`ifdef PEAK_TRACK_EN
  logic [FW-1:0] peak_freq_d;
  logic [DW-1:0] peak_mag_d;
`endif

  assign busy    = (state != IDLE);
  assign acc_sum = acc_q + AW'(adc_data);
  assign avg_n   = 8'd1 << avg_q;

  // Both handshakes (adc_req/adc_ack, res_valid/res_ready) transfer on a rising edge where
  // both signals are high; valid/req never drop before the transfer unless abort or reset hits.
  always_comb begin
    state_d     = state;
    step_d      = step_q;
    npts_d      = npts_q;
    settle_d    = settle_q;
    avg_d       = avg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    scnt_d      = scnt_q;
    freq_word_d = freq_word;
    res_freq_d  = res_freq;
    res_mag_d   = res_mag;
    freq_load_d = 1'b0;
    adc_req_d   = adc_req;
    res_valid_d = res_valid;
    done_d      = 1'b0;
`ifdef PEAK_TRACK_EN
    peak_freq_d = peak_freq;
    peak_mag_d  = peak_mag;
`endif
    if (abort) begin
      state_d     = IDLE;
      adc_req_d   = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef PEAK_TRACK_EN
            peak_freq_d = '0;
            peak_mag_d  = '0;
`endif
            if (n_points != 10'd0) begin
              step_d      = f_step;
              npts_d      = n_points;
              settle_d    = settle_cycles;
              avg_d       = avg_log2;
              freq_word_d = f_start;
              freq_load_d = 1'b1;
              idx_d       = '0;
              cnt_d       = settle_cycles;
              state_d     = SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == 16'd0) begin
            adc_req_d = 1'b1;
            acc_d     = '0;
            scnt_d    = '0;
            state_d   = SAMPLE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        SAMPLE: begin
          if (adc_req && adc_ack) begin
            acc_d  = acc_sum;
            scnt_d = scnt_q + 8'd1;
            if (scnt_q + 8'd1 == avg_n) begin
              res_mag_d   = DW'(acc_sum >> avg_q);
              res_freq_d  = freq_word;
              adc_req_d   = 1'b0;
              res_valid_d = 1'b1;
              state_d     = EMIT;
            end
          end
        end
        EMIT: begin
          if (res_valid && res_ready) begin
            res_valid_d = 1'b0;
`ifdef PEAK_TRACK_EN
            if (res_mag > peak_mag) begin
              peak_mag_d  = res_mag;
              peak_freq_d = res_freq;
            end
`endif
            if (idx_q == npts_q - 10'd1) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              freq_word_d = freq_word + step_q;
              freq_load_d = 1'b1;
              idx_d       = idx_q + 10'd1;
              cnt_d       = settle_q;
              state_d     = SETTLE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_q    <= '0;
      npts_q    <= '0;
      settle_q  <= '0;
      avg_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      scnt_q    <= '0;
      freq_word <= '0;
      freq_load <= 1'b0;
      adc_req   <= 1'b0;
      res_valid <= 1'b0;
      res_freq  <= '0;
      res_mag   <= '0;
      done      <= 1'b0;
`ifdef PEAK_TRACK_EN
      peak_freq <= '0;
      peak_mag  <= '0;
`endif
    end else begin
      state     <= state_d;
      step_q    <= step_d;
      npts_q    <= npts_d;
      settle_q  <= settle_d;
      avg_q     <= avg_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      scnt_q    <= scnt_d;
      freq_word <= freq_word_d;
      freq_load <= freq_load_d;
      adc_req   <= adc_req_d;
      res_valid <= res_valid_d;
      res_freq  <= res_freq_d;
      res_mag   <= res_mag_d;
      done      <= done_d;
`ifdef PEAK_TRACK_EN
      peak_freq <= peak_freq_d;
      peak_mag  <= peak_mag_d;
`endif
    end
  end

endmodule
